// File: rtl/cond_pkg.sv
// Shared definitions for the condition-input conditioner: debounce FSM
// state encoding and default parameter values.
package cond_pkg;

   typedef enum logic {
      ST_STABLE   = 1'b0,
      ST_COUNTING = 1'b1
   } deb_state_t;

   localparam int N_COND_DEF          = 2;
   localparam int SYNC_STAGES_DEF     = 2;
   localparam int DEBOUNCE_CYCLES_DEF = 4;

endpackage

// File: rtl/cond_debounce_bit.sv
// One condition bit: synchroniser chain, two-state debounce FSM and counter.
// load is high in the cycle whose rising edge commits a new stable value.
module cond_debounce_bit
   import cond_pkg::*;
#(
   parameter int SYNC_STAGES     = SYNC_STAGES_DEF,
   parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
   parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES) + 1
) (
   input  logic clk,
   input  logic rst,
   input  logic raw,
   input  logic enable,
   output logic stable,
   output logic load
);

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   s;
   deb_state_t             state_q, state_d;
   logic [CNT_W-1:0]       cnt_q, cnt_d;

   always_ff @(posedge clk) begin
      if (rst) begin
         sync_q <= '0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], raw};
      end
   end

   assign s = sync_q[SYNC_STAGES-1];

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_STABLE;
         cnt_q   <= '0;
         stable  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         if (load) begin
            stable <= ~stable;
         end
      end
   end

   // With enable low nothing advances, so the partial count is kept for re-enable.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      load    = 1'b0;
      if (enable) begin
         case (state_q)
            ST_STABLE: begin
               if (s != stable) begin
                  if (DEBOUNCE_CYCLES == 1) begin
                     load = 1'b1;
                  end else begin
                     cnt_d   = CNT_W'(1);
                     state_d = ST_COUNTING;
                  end
               end
            end
            ST_COUNTING: begin
               if (s == stable) begin
                  cnt_d   = '0;
                  state_d = ST_STABLE;
               end else if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                  load    = 1'b1;
                  cnt_d   = '0;
                  state_d = ST_STABLE;
               end else begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
            end
            default: begin
               cnt_d   = '0;
               state_d = ST_STABLE;
            end
         endcase
      end
   end

endmodule

// File: rtl/cond_input_conditioner.sv
// Conditions raw FSM condition inputs: per-bit synchronise and debounce,
// then warm-up gating and registered change / edge pulses.
module cond_input_conditioner
   import cond_pkg::*;
#(
   parameter int N_COND          = N_COND_DEF,
   parameter int SYNC_STAGES     = SYNC_STAGES_DEF,
   parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
   parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES) + 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [N_COND-1:0] raw_in,
   input  logic              enable,
   output logic [N_COND-1:0] cond_sig,
   output logic              cond_valid,
   output logic              cond_changed,
   output logic [N_COND-1:0] edge_rise,
   output logic [N_COND-1:0] edge_fall
);

   localparam int WARM   = SYNC_STAGES + DEBOUNCE_CYCLES;
   localparam int WARM_W = $clog2(WARM + 1);

   logic [N_COND-1:0] load;
   logic [WARM_W-1:0] warm_cnt;

   for (genvar i = 0; i < N_COND; i++) begin : g_bit
      cond_debounce_bit #(
         .SYNC_STAGES    (SYNC_STAGES),
         .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
         .CNT_W          (CNT_W)
      ) u_bit (
         .clk   (clk),
         .rst   (rst),
         .raw   (raw_in[i]),
         .enable(enable),
         .stable(cond_sig[i]),
         .load  (load[i])
      );
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         warm_cnt   <= '0;
         cond_valid <= 1'b0;
      end else if (!cond_valid) begin
         warm_cnt <= warm_cnt + WARM_W'(1);
         if (warm_cnt == WARM_W'(WARM - 1)) begin
            cond_valid <= 1'b1;
         end
      end
   end

   // Pulses are registered on the same edge that commits cond_sig, so they
   // line up with the first cycle the new value is visible.
   always_ff @(posedge clk) begin
      if (rst) begin
         cond_changed <= 1'b0;
         edge_rise    <= '0;
         edge_fall    <= '0;
      end else if (cond_valid) begin
         cond_changed <= |load;
         edge_rise    <= load & ~cond_sig;
         edge_fall    <= load & cond_sig;
      end else begin
         cond_changed <= 1'b0;
         edge_rise    <= '0;
         edge_fall    <= '0;
      end
   end

endmodule

// File: tb/tb_cond_input_conditioner.sv
// Directed bench for cond_input_conditioner at default parameters, with a
// small two-state Moore FSM consuming cond_sig.
module tb_cond_input_conditioner;

   logic       clk = 1'b0;
   logic       rst;
   logic [1:0] raw_in;
   logic       enable;
   logic [1:0] cond_sig;
   logic       cond_valid;
   logic       cond_changed;
   logic [1:0] edge_rise;
   logic [1:0] edge_fall;
   logic       fsm_state;

   int n_cmp = 0;
   int n_bad = 0;

   cond_input_conditioner #(
      .N_COND         (2),
      .SYNC_STAGES    (2),
      .DEBOUNCE_CYCLES(4)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .raw_in      (raw_in),
      .enable      (enable),
      .cond_sig    (cond_sig),
      .cond_valid  (cond_valid),
      .cond_changed(cond_changed),
      .edge_rise   (edge_rise),
      .edge_fall   (edge_fall)
   );

   always #5 clk = ~clk;

   // Downstream FSM: state 0 -> 1 once it sees cond_sig == 2'b11.
   always @(posedge clk) begin
      if (rst) fsm_state <= 1'b0;
      else if (!fsm_state && cond_sig == 2'b11) fsm_state <= 1'b1;
   end

   typedef struct {
      logic       rst;
      logic       en;
      logic [1:0] raw;
      logic [1:0] sig;
      logic       vld;
      logic       chg;
      logic [1:0] rise;
      logic [1:0] fall;
   } vec_t;

   vec_t tbl[$];

   function automatic vec_t mk(logic r, logic e, logic [1:0] rw, logic [1:0] sg,
                               logic v, logic c, logic [1:0] ri, logic [1:0] fa);
      vec_t t;
      t.rst = r; t.en = e; t.raw = rw; t.sig = sg;
      t.vld = v; t.chg = c; t.rise = ri; t.fall = fa;
      return t;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(string nm, logic [7:0] got, logic [7:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %b expected %b", nm, got, exp);
      end
   endtask

   function automatic logic [7:0] outs();
      return {1'b0, cond_sig, cond_valid, cond_changed, edge_rise, edge_fall};
   endfunction

   function automatic logic [7:0] pack(logic [1:0] sg, logic v, logic c,
                                       logic [1:0] ri, logic [1:0] fa);
      return {1'b0, sg, v, c, ri, fa};
   endfunction

   initial begin
      rst = 1'b1; enable = 1'b1; raw_in = 2'b00;

      // Reset, warm-up, glitch, clean rise, single-bit fall.
      for (int i = 0; i < 3; i++)   tbl.push_back(mk(1, 1, 2'b00, 2'b00, 0, 0, 2'b00, 2'b00));
      for (int i = 3; i < 8; i++)   tbl.push_back(mk(0, 1, 2'b00, 2'b00, 0, 0, 2'b00, 2'b00));
      tbl.push_back(mk(0, 1, 2'b00, 2'b00, 1, 0, 2'b00, 2'b00));
      for (int i = 9; i < 11; i++)  tbl.push_back(mk(0, 1, 2'b01, 2'b00, 1, 0, 2'b00, 2'b00));
      for (int i = 11; i < 17; i++) tbl.push_back(mk(0, 1, 2'b00, 2'b00, 1, 0, 2'b00, 2'b00));
      for (int i = 17; i < 22; i++) tbl.push_back(mk(0, 1, 2'b11, 2'b00, 1, 0, 2'b00, 2'b00));
      tbl.push_back(mk(0, 1, 2'b11, 2'b11, 1, 1, 2'b11, 2'b00));
      tbl.push_back(mk(0, 1, 2'b11, 2'b11, 1, 0, 2'b00, 2'b00));
      for (int i = 24; i < 29; i++) tbl.push_back(mk(0, 1, 2'b10, 2'b11, 1, 0, 2'b00, 2'b00));
      tbl.push_back(mk(0, 1, 2'b10, 2'b10, 1, 1, 2'b00, 2'b01));
      tbl.push_back(mk(0, 1, 2'b10, 2'b10, 1, 0, 2'b00, 2'b00));

      for (int i = 0; i < tbl.size(); i++) begin
         rst = tbl[i].rst; enable = tbl[i].en; raw_in = tbl[i].raw;
         tick();
         chk($sformatf("row%0d", i), outs(),
             pack(tbl[i].sig, tbl[i].vld, tbl[i].chg, tbl[i].rise, tbl[i].fall));
      end

      // Fall on bit 1 with enable low for three edges mid-count.
      raw_in = 2'b00;
      for (int k = 0; k < 10; k++) begin
         enable = !(k >= 4 && k <= 6);
         tick();
         chk($sformatf("engap%0d", k), outs(),
             pack((k >= 8) ? 2'b00 : 2'b10, 1'b1, (k == 8), 2'b00,
                  (k == 8) ? 2'b10 : 2'b00));
      end
      enable = 1'b1;

      // Reset two edges into a count; change completes during warm-up without pulses.
      raw_in = 2'b10;
      for (int k = 0; k < 4; k++) begin
         tick();
         chk($sformatf("prerst%0d", k), outs(), pack(2'b00, 1'b1, 1'b0, 2'b00, 2'b00));
      end
      rst = 1'b1;
      tick();
      chk("rst_mid", outs(), pack(2'b00, 1'b0, 1'b0, 2'b00, 2'b00));
      rst = 1'b0;
      for (int j = 1; j <= 7; j++) begin
         tick();
         chk($sformatf("rewarm%0d", j), outs(),
             pack((j >= 6) ? 2'b10 : 2'b00, (j >= 6), 1'b0, 2'b00, 2'b00));
      end

      // FSM integration: state 1 on the edge after cond_sig becomes 2'b11.
      raw_in = 2'b11;
      for (int k = 0; k < 7; k++) begin
         tick();
         chk($sformatf("fsm_out%0d", k), outs(),
             pack((k >= 5) ? 2'b11 : 2'b10, 1'b1, (k == 5),
                  (k == 5) ? 2'b01 : 2'b00, 2'b00));
         chk($sformatf("fsm_state%0d", k), {7'd0, fsm_state}, {7'd0, (k >= 6)});
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
